// File: rtl/rvm_socket_ctrl_pkg.sv
// Shared register offsets, response codes, ID constant and FSM state types for rvm_socket_ctrl.
package rvm_socket_ctrl_pkg;

    localparam logic [2:0] RegBootAddr   = 3'd0;
    localparam logic [2:0] RegIrqPending = 3'd1;
    localparam logic [2:0] RegIrqEnable  = 3'd2;
    localparam logic [2:0] RegIrqSet     = 3'd3;
    localparam logic [2:0] RegId         = 3'd4;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    localparam logic [31:0] IdValue = 32'h524D_5343;

    typedef enum logic {WrIdle, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rvm_socket_ctrl_irq.sv
// Interrupt pending/enable storage with registered irq output.
// RVM_SOCKET_CTRL_IRQ_EDGE_EN selects rising-edge source detection; default is level.
module rvm_socket_ctrl_irq #(
    parameter int unsigned NUM_IRQ = 3
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic               en_we_i,
    input  logic [NUM_IRQ-1:0] en_wmask_i,
    input  logic [NUM_IRQ-1:0] en_wdata_i,
    input  logic [NUM_IRQ-1:0] sw_set_i,
    input  logic [NUM_IRQ-1:0] sw_clr_i,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic [NUM_IRQ-1:0] enable_o,
    output logic [NUM_IRQ-1:0] irq_o
);

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_irq;
    logic [NUM_IRQ-1:0] w_hw_set;

`ifdef RVM_SOCKET_CTRL_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] r_src_prev;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_src_prev <= '0;
        end else begin
            r_src_prev <= irq_src_i;
        end
    end

    assign w_hw_set = irq_src_i & ~r_src_prev;
`else
    assign w_hw_set = irq_src_i;
`endif

    // Sets (hardware or software) always win over a software clear of the same bit.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_irq     <= '0;
        end else begin
            r_pending <= (r_pending & ~sw_clr_i) | sw_set_i | w_hw_set;
            if (en_we_i) begin
                r_enable <= (r_enable & ~en_wmask_i) | (en_wdata_i & en_wmask_i);
            end
            r_irq <= r_pending & r_enable;
        end
    end

    assign pending_o = r_pending;
    assign enable_o  = r_enable;
    assign irq_o     = r_irq;

endmodule

// File: rtl/rvm_socket_ctrl.sv
// AXI4-Lite register block driving an RVM core socket's boot address and interrupt lines.
// Optional macro RVM_SOCKET_CTRL_IRQ_EDGE_EN makes interrupt sources edge-sensitive.
module rvm_socket_ctrl
    import rvm_socket_ctrl_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH        = 32,
    parameter int unsigned           ADDR_WIDTH        = 32,
    parameter int unsigned           NUM_IRQ           = 3,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR_DEFAULT = '0
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    input  logic [NUM_IRQ-1:0]      irq_src_i,
    output logic [ADDR_WIDTH-1:0]   bootaddr_o,
    output logic [NUM_IRQ-1:0]      irq_o
);

    wr_state_e r_wr_state, w_wr_state_next;
    rd_state_e r_rd_state, w_rd_state_next;

    logic                  w_awready, w_bvalid, w_arready, w_rvalid;
    logic                  w_wr_fire, w_rd_fire;
    logic                  w_wr_ok, w_rd_ok;
    logic [2:0]            w_wr_idx, w_rd_idx;
    logic [DATA_WIDTH-1:0] w_wmask, w_wdata_m, w_boot_wide, w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [NUM_IRQ-1:0]    w_pending, w_enable;
    logic                  w_en_we;
    logic [NUM_IRQ-1:0]    w_sw_set, w_sw_clr;

    logic [ADDR_WIDTH-1:0] r_bootaddr;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_unused_addr;
    assign w_unused_addr = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign w_wr_idx  = s_axil_awaddr[4:2];
    assign w_rd_idx  = s_axil_araddr[4:2];
    assign w_wr_ok   = (s_axil_awaddr[ADDR_WIDTH-1:5] == '0) && (w_wr_idx <= RegId);
    assign w_rd_ok   = (s_axil_araddr[ADDR_WIDTH-1:5] == '0) && (w_rd_idx <= RegId);
    assign w_wmask   = strb_to_mask(s_axil_wstrb);
    assign w_wdata_m = s_axil_wdata & w_wmask;

    // Write FSM
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_state <= WrIdle;
        end else begin
            r_wr_state <= w_wr_state_next;
        end
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        unique case (r_wr_state)
            WrIdle:  if (w_wr_fire) w_wr_state_next = WrResp;
            WrResp:  if (s_axil_bready) w_wr_state_next = WrIdle;
            default: w_wr_state_next = WrIdle;
        endcase
    end

    // AW and W are only ever accepted together; reset_ni keeps ready low while in reset.
    always_comb begin
        w_awready = 1'b0;
        w_bvalid  = 1'b0;
        unique case (r_wr_state)
            WrIdle:  w_awready = s_axil_awvalid & s_axil_wvalid & reset_ni;
            WrResp:  w_bvalid = 1'b1;
            default: ;
        endcase
    end

    assign w_wr_fire = w_awready;

    // Read FSM
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rd_state <= RdIdle;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        unique case (r_rd_state)
            RdIdle:  if (w_rd_fire) w_rd_state_next = RdData;
            RdData:  if (s_axil_rready) w_rd_state_next = RdIdle;
            default: w_rd_state_next = RdIdle;
        endcase
    end

    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        unique case (r_rd_state)
            RdIdle:  w_arready = reset_ni;
            RdData:  w_rvalid = 1'b1;
            default: ;
        endcase
    end

    assign w_rd_fire = w_arready & s_axil_arvalid;

    assign w_boot_wide = DATA_WIDTH'(r_bootaddr);

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RespOkay;
        if (!w_rd_ok) begin
            w_rd_resp = RespSlvErr;
        end else begin
            unique case (w_rd_idx)
                RegBootAddr:   w_rd_data = w_boot_wide;
                RegIrqPending: w_rd_data = DATA_WIDTH'(w_pending);
                RegIrqEnable:  w_rd_data = DATA_WIDTH'(w_enable);
                RegId:         w_rd_data = DATA_WIDTH'(IdValue);
                default:       w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_bootaddr <= BOOT_ADDR_DEFAULT;
            r_bresp    <= RespOkay;
            r_rresp    <= RespOkay;
            r_rdata    <= '0;
        end else begin
            if (w_wr_fire) begin
                r_bresp <= w_wr_ok ? RespOkay : RespSlvErr;
                if (w_wr_ok && (w_wr_idx == RegBootAddr)) begin
                    r_bootaddr <= ADDR_WIDTH'((w_boot_wide & ~w_wmask) | w_wdata_m);
                end
            end
            if (w_rd_fire) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    assign w_en_we  = w_wr_fire && w_wr_ok && (w_wr_idx == RegIrqEnable);
    assign w_sw_set = (w_wr_fire && w_wr_ok && (w_wr_idx == RegIrqSet)) ?
                      w_wdata_m[NUM_IRQ-1:0] : '0;
    assign w_sw_clr = (w_wr_fire && w_wr_ok && (w_wr_idx == RegIrqPending)) ?
                      w_wdata_m[NUM_IRQ-1:0] : '0;

    rvm_socket_ctrl_irq #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .irq_src_i  (irq_src_i),
        .en_we_i    (w_en_we),
        .en_wmask_i (w_wmask[NUM_IRQ-1:0]),
        .en_wdata_i (s_axil_wdata[NUM_IRQ-1:0]),
        .sw_set_i   (w_sw_set),
        .sw_clr_i   (w_sw_clr),
        .pending_o  (w_pending),
        .enable_o   (w_enable),
        .irq_o      (irq_o)
    );

    assign s_axil_awready = w_awready;
    assign s_axil_wready  = w_awready;
    assign s_axil_bvalid  = w_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = w_arready;
    assign s_axil_rvalid  = w_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign bootaddr_o     = r_bootaddr;

endmodule

// File: tb/tb_rvm_socket_ctrl.sv
// Self-checking bench for rvm_socket_ctrl against a cycle-level behavioural register model.
module tb_rvm_socket_ctrl;

    localparam logic [31:0] BootDef = 32'h0000_0000;
    localparam logic [31:0] IdVal   = 32'h524D_5343;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, bootaddr;
    logic [2:0]  irq_src = '0;
    logic [2:0]  irq;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rvm_socket_ctrl #(
        .DATA_WIDTH        (32),
        .ADDR_WIDTH        (32),
        .NUM_IRQ           (3),
        .BOOT_ADDR_DEFAULT (BootDef)
    ) dut (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .irq_src_i      (irq_src),
        .bootaddr_o     (bootaddr),
        .irq_o          (irq)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_boot;
    logic [2:0]  m_pend, m_en, m_irq, m_prev;
    logic        m_bbusy;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[31:5] == 27'd0) && (a[4:2] <= 3'd4);
    endfunction

    function automatic void m_read(input logic [31:0] a, output logic [31:0] d,
                                   output logic [1:0] r);
        d = 32'd0;
        r = 2'b00;
        if (!addr_ok(a)) r = 2'b10;
        else if (a[4:2] == 3'd0) d = m_boot;
        else if (a[4:2] == 3'd1) d = {29'd0, m_pend};
        else if (a[4:2] == 3'd2) d = {29'd0, m_en};
        else if (a[4:2] == 3'd4) d = IdVal;
    endfunction

    logic        m_fire;
    logic [31:0] m_mask, m_wm;
    int          m_sel;
    logic [2:0]  m_hw, m_set, m_clr;

    assign m_fire = !m_bbusy && awvalid && wvalid;
    assign m_mask = strb_mask(wstrb);
    assign m_wm   = wdata & m_mask;
    assign m_sel  = (m_fire && addr_ok(awaddr)) ? int'(awaddr[4:2]) : -1;
    assign m_set  = (m_sel == 3) ? m_wm[2:0] : 3'b000;
    assign m_clr  = (m_sel == 1) ? m_wm[2:0] : 3'b000;
`ifdef RVM_SOCKET_CTRL_IRQ_EDGE_EN
    assign m_hw = irq_src & ~m_prev;
`else
    assign m_hw = irq_src;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot  <= BootDef;
            m_pend  <= 3'b000;
            m_en    <= 3'b000;
            m_irq   <= 3'b000;
            m_prev  <= 3'b000;
            m_bbusy <= 1'b0;
        end else begin
            m_irq   <= m_pend & m_en;
            m_prev  <= irq_src;
            m_bbusy <= m_bbusy ? !bready : (awvalid && wvalid);
            if (m_sel == 0) m_boot <= (m_boot & ~m_mask) | m_wm;
            if (m_sel == 2) m_en <= (m_en & ~m_mask[2:0]) | m_wm[2:0];
            m_pend <= (m_pend & ~m_clr) | m_set | m_hw;
        end
    end

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL aw_timeout awready=%0b required 1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL b_timeout bvalid=%0b required 1", bvalid);
        end
        resp = bresp;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                            output logic [31:0] exp_d, output logic [1:0] exp_r);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL ar_timeout arready=%0b required 1", arready);
        end
        m_read(a, exp_d, exp_r);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL r_timeout rvalid=%0b required 1", rvalid);
        end
        d = rdata;
        r = rresp;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bootaddr !== BootDef) begin
            bad++; $display("FAIL reset_boot got=%h want=%h", bootaddr, BootDef);
        end
        total++;
        if (irq !== 3'b000) begin
            bad++; $display("FAIL reset_irq got=%b want=000", irq);
        end
        total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_hs got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
        end
        total++;
        if ({bresp, rresp, rdata} !== 36'd0) begin
            bad++; $display("FAIL reset_resp got=%h/%h/%h want 0", bresp, rresp, rdata);
        end
        rst_n = 1'b1;
        axi_read(32'h10, d, r, ed, er);
        total++;
        if (d !== IdVal || r !== 2'b00) begin
            bad++; $display("FAIL id_read got=%h/%b want=%h/00", d, r, IdVal);
        end
    endtask

    task automatic test_bootaddr();
        logic [1:0]  r, er;
        logic [31:0] d, ed;
        axi_write(32'h00, 32'h8000_1234, 4'b0011, r);
        total++;
        if (r !== 2'b00) begin
            bad++; $display("FAIL boot_bresp got=%b want=00", r);
        end
        total++;
        if (bootaddr !== 32'h0000_1234) begin
            bad++; $display("FAIL boot_strb got=%h want=00001234", bootaddr);
        end
        axi_read(32'h00, d, r, ed, er);
        total++;
        if (d !== 32'h0000_1234 || d !== ed) begin
            bad++; $display("FAIL boot_read got=%h want=00001234 model=%h", d, ed);
        end
    endtask

    task automatic test_irq();
        logic [1:0]  r, er;
        logic [31:0] d, ed;
        axi_write(32'h08, 32'h5, 4'hF, r);
        @(negedge clk);
        irq_src = 3'b001;
        @(negedge clk);
        irq_src = 3'b000;
        total++;
        if (irq[0] !== 1'b0) begin
            bad++; $display("FAIL irq0_early got=%b want=0", irq[0]);
        end
        @(negedge clk);
        total++;
        if (irq[0] !== 1'b1) begin
            bad++; $display("FAIL irq0_set got=%b want=1", irq[0]);
        end
        axi_write(32'h04, 32'h1, 4'hF, r);
        @(negedge clk);
        total++;
        if (irq[0] !== 1'b0) begin
            bad++; $display("FAIL irq0_clear got=%b want=0", irq[0]);
        end
        @(negedge clk);
        irq_src = 3'b010;
        @(negedge clk);
        irq_src = 3'b000;
        repeat (3) @(negedge clk);
        total++;
        if (irq !== 3'b000) begin
            bad++; $display("FAIL irq1_masked got=%b want=000", irq);
        end
        axi_read(32'h04, d, r, ed, er);
        total++;
        if (d !== 32'h2 || d !== ed) begin
            bad++; $display("FAIL pend_read got=%h want=2 model=%h", d, ed);
        end
        axi_write(32'h0C, 32'h4, 4'hF, r);
        axi_read(32'h04, d, r, ed, er);
        total++;
        if (d !== 32'h6 || d !== ed) begin
            bad++; $display("FAIL pend_set got=%h want=6 model=%h", d, ed);
        end
        total++;
        if (irq !== 3'b100 || irq !== m_irq) begin
            bad++; $display("FAIL irq2_set got=%b want=100 model=%b", irq, m_irq);
        end
        axi_read(32'h0C, d, r, ed, er);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL set_reads0 got=%h want=0", d);
        end
    endtask

    task automatic test_slverr();
        logic [1:0]  r, er;
        logic [31:0] d, ed;
        logic [31:0] boot_before;
        boot_before = bootaddr;
        axi_write(32'h1C, 32'hFFFF_FFFF, 4'hF, r);
        total++;
        if (r !== 2'b10) begin
            bad++; $display("FAIL err_bresp got=%b want=10", r);
        end
        axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, r);
        total++;
        if (r !== 2'b10 || bootaddr !== boot_before) begin
            bad++; $display("FAIL err_high got=%b/%h want=10/%h", r, bootaddr, boot_before);
        end
        axi_read(32'h40, d, r, ed, er);
        total++;
        if (r !== 2'b10 || d !== 32'h0) begin
            bad++; $display("FAIL err_read got=%b/%h want=10/0", r, d);
        end
        axi_read(32'h08, d, r, ed, er);
        total++;
        if (d !== 32'h5 || r !== 2'b00) begin
            bad++; $display("FAIL err_noeffect got=%h want=5", d);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        awaddr = 32'h00; wdata = 32'hCAFE_0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
                bad++; $display("FAIL aw_alone cyc=%0d got=%b%b want=00", i, awready, wready);
            end
            @(negedge clk);
        end
        wvalid = 1'b1;
        #1;
        total++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            bad++; $display("FAIL aw_w_both got=%b%b want=11", awready, wready);
        end
        @(negedge clk);
        bready = 1'b0;
        awaddr = 32'h08; wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || bresp !== 2'b00) begin
                bad++;
                $display("FAIL b_hold cyc=%0d got bvalid=%b awready=%b want 1/0", i, bvalid,
                         awready);
            end
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        total++;
        if (bvalid !== 1'b0 || bootaddr !== 32'hCAFE_0000 || m_en !== 3'b101) begin
            bad++; $display("FAIL b_release got bvalid=%b boot=%h want 0/cafe0000", bvalid,
                            bootaddr);
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        @(negedge clk);
        araddr = 32'h10; arvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid) begin
                cnt++;
                total++;
                if (rdata !== IdVal) begin
                    bad++; $display("FAIL b2b_data got=%h want=%h", rdata, IdVal);
                end
            end
        end
        arvalid = 1'b0;
        total++;
        if (cnt != 3) begin
            bad++; $display("FAIL b2b_rate got=%0d want=3", cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        @(negedge clk);
        awaddr = 32'h00; wdata = 32'h1111_1111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 20) begin
            @(negedge clk); n++;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bvalid !== 1'b0 || bootaddr !== BootDef || irq !== 3'b000) begin
            bad++; $display("FAIL mid_reset got bvalid=%b boot=%h irq=%b want 0/%h/000", bvalid,
                            bootaddr, irq, BootDef);
        end
        @(negedge clk);
        bready = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        logic [31:0] a, d, ed;
        logic [1:0]  r, er;
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h40};
        for (int it = 0; it < 120; it++) begin
            @(negedge clk);
            irq_src = 3'($urandom_range(0, 7));
            a = addrs[$urandom_range(0, 7)];
            case ($urandom_range(0, 2))
                0: begin
                    axi_write(a, $urandom, 4'($urandom_range(0, 15)), r);
                    total++;
                    if (r !== (addr_ok(a) ? 2'b00 : 2'b10)) begin
                        bad++; $display("FAIL rnd_bresp a=%h got=%b", a, r);
                    end
                end
                1: begin
                    axi_read(a, d, r, ed, er);
                    total++;
                    if (d !== ed || r !== er) begin
                        bad++; $display("FAIL rnd_read a=%h got=%h/%b want=%h/%b", a, d, r, ed, er);
                    end
                end
                default: repeat (2) @(negedge clk);
            endcase
            total++;
            if (irq !== m_irq || bootaddr !== m_boot) begin
                bad++; $display("FAIL rnd_state got irq=%b boot=%h want irq=%b boot=%h", irq,
                                bootaddr, m_irq, m_boot);
            end
        end
        irq_src = 3'b000;
    endtask

    initial begin
        test_reset();
        test_bootaddr();
        test_irq();
        test_slverr();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
